// File: rtl/neuron_mac.sv
// ---------------------------------------------------------------------------
// neuron_mac: multiply-accumulate front end of a neuron.
//
// Each accepted beat multiplies a signed activation by a signed Q2.13 weight.
// The products of a vector are summed, the bias from the vector's first beat
// is added, and the result is clipped to the 31-bit activation range before
// it is handed to the sigmoid stage.
//
// Parameters
//   W_FRAC    fractional bits of the weight format (default 13)
//   ACC_W     accumulator width (default 48)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle
//   x_in       signed activation, 100000000 = 1.0
//   w_in       signed weight, Q2.13
//   in_last    final beat of a vector
//   bias       signed bias, sampled on the first beat of a vector
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   x_out      signed clipped weighted sum
//   sat        x_out was clipped (qualified by out_valid)
// ---------------------------------------------------------------------------
module neuron_mac #(
    parameter int W_FRAC = 13,
    parameter int ACC_W  = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] x_in,
    input  logic [15:0] w_in,
    input  logic        in_last,
    input  logic [30:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] x_out,
    output logic        sat
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        OUT
    } state_e;

    // Largest and smallest values representable on the 31-bit output.
    localparam logic signed [ACC_W-1:0] POS_LIM = {{(ACC_W-31){1'b0}}, 31'h3FFF_FFFF};
    localparam logic signed [ACC_W-1:0] NEG_LIM = {{(ACC_W-31){1'b1}}, 31'h4000_0000};

    state_e                   state_q;
    logic                     inReady_q;
    logic                     outValid_q;
    logic [30:0]              xOut_q;
    logic                     sat_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  product_q;
    logic                     prodValid_q;
    logic [30:0]              bias_q;

    logic                     xfer;
    logic signed [46:0]       xExt;
    logic signed [46:0]       wExt;
    logic signed [46:0]       prodFull;
    logic signed [46:0]       prodShift;
    logic signed [ACC_W-1:0]  product_d;
    logic signed [ACC_W-1:0]  biasExt;
    logic signed [ACC_W-1:0]  sum_d;
    logic                     posSat;
    logic                     negSat;

    assign xfer = in_valid & inReady_q;

    // Both operands are widened to the full 47-bit product width so the
    // multiply is exact; the arithmetic shift then floors toward -infinity.
    assign xExt      = {{16{x_in[30]}}, x_in};
    assign wExt      = {{31{w_in[15]}}, w_in};
    assign prodFull  = xExt * wExt;
    assign prodShift = prodFull >>> W_FRAC;
    assign product_d = {{(ACC_W-47){prodShift[46]}}, prodShift};

    assign biasExt = {{(ACC_W-31){bias_q[30]}}, bias_q};
    assign sum_d   = acc_q + biasExt;
    assign posSat  = (sum_d > POS_LIM);
    assign negSat  = (sum_d < NEG_LIM);

    // Control FSM with the two-stage datapath. The last product is folded
    // into the accumulator during DRAIN; the first cycle of OUT registers
    // the biased, clipped sum and raises out_valid on the following edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            inReady_q   <= 1'b0;
            outValid_q  <= 1'b0;
            xOut_q      <= '0;
            sat_q       <= 1'b0;
            acc_q       <= '0;
            product_q   <= '0;
            prodValid_q <= 1'b0;
            bias_q      <= '0;
        end else begin
            prodValid_q <= xfer;
            if (xfer) begin
                product_q <= product_d;
            end

            // A new vector starts from zero; nothing is pending in IDLE.
            if (state_q == IDLE && xfer) begin
                acc_q <= '0;
            end else if (prodValid_q) begin
                acc_q <= acc_q + product_q;
            end

            case (state_q)
                IDLE: begin
                    inReady_q <= 1'b1;
                    if (xfer) begin
                        bias_q <= bias;
                        if (in_last) begin
                            state_q   <= DRAIN;
                            inReady_q <= 1'b0;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer && in_last) begin
                        state_q   <= DRAIN;
                        inReady_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    state_q <= OUT;
                end
                OUT: begin
                    if (!outValid_q) begin
                        outValid_q <= 1'b1;
                        sat_q      <= posSat | negSat;
                        if (posSat) begin
                            xOut_q <= POS_LIM[30:0];
                        end else if (negSat) begin
                            xOut_q <= NEG_LIM[30:0];
                        end else begin
                            xOut_q <= sum_d[30:0];
                        end
                    end else if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                        inReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    inReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign x_out     = xOut_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac: self-checking bench for neuron_mac.
//
// The stimulus side sends vectors and pushes the expected result of every
// completed vector into a queue; a monitor pops and compares whenever a
// result is handed over. Expected results come from an arithmetic model
// (exact products, floor division, clipping).
// ---------------------------------------------------------------------------
module tb_neuron_mac;

    localparam int W_FRAC = 13;
    localparam int ACC_W  = 48;
    localparam longint POS_MAX = 64'sd1073741823;
    localparam longint NEG_MIN = -64'sd1073741824;

    typedef struct {
        longint x;
        longint s;
    } result_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [30:0] x_in = '0;
    logic [15:0] w_in = '0;
    logic        in_last = 1'b0;
    logic [30:0] bias = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [30:0] x_out;
    logic        sat;

    int      testsRun = 0;
    int      testsFailed = 0;
    int      resultCount = 0;
    bit      readyMode = 1'b0;
    bit      readyForce = 1'b0;
    int      vx [256];
    int      vw [256];
    result_t expQ [$];

    neuron_mac #(.W_FRAC(W_FRAC), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    // Consumer: either a fixed out_ready level or a random one every cycle.
    always begin
        @(posedge clk);
        #2;
        out_ready = readyMode ? 1'($urandom_range(0, 1)) : readyForce;
    end

    task automatic checkOutput(input string name, input longint got, input longint want);
        testsRun++;
        if (got != want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reference result of a vector held in vx/vw: exact products, floored
    // division by 2^W_FRAC, plain sum, bias, then clip.
    function automatic result_t model(input int len, input int biasVal);
        result_t r;
        longint  acc = 0;
        longint  p;
        longint  q;
        longint  scale = longint'(1) << W_FRAC;
        for (int i = 0; i < len; i++) begin
            p = longint'(vx[i]) * longint'(vw[i]);
            q = p / scale;
            if (p < 0 && (p % scale) != 0) q = q - 1;
            acc = acc + q;
        end
        acc = acc + longint'(biasVal);
        if (acc > POS_MAX) begin
            r.x = POS_MAX;
            r.s = 1;
        end else if (acc < NEG_MIN) begin
            r.x = NEG_MIN;
            r.s = 1;
        end else begin
            r.x = acc;
            r.s = 0;
        end
        return r;
    endfunction

    // Waits (bounded) until the currently driven beat is accepted. Called
    // with inputs already set; returns 1 ns after the transfer edge.
    task automatic waitXfer();
        int guard = 0;
        while (!in_ready && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 300) begin
            checkOutput("xfer_timeout", 1, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Sends beats 0..len-1 of a vector of 'total' beats from vx/vw. Later
    // beats carry a random bias that must be ignored.
    task automatic applyStimulus(input int len, input int total, input int biasVal, input bit doPush);
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            x_in     = vx[i][30:0];
            w_in     = vw[i][15:0];
            in_last  = (i == total - 1);
            bias     = (i == 0) ? biasVal[30:0] : 31'($urandom);
            waitXfer();
        end
        if (doPush) expQ.push_back(model(total, biasVal));
    endtask

    // Idle cycles with garbage on the data inputs.
    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            x_in    = 31'($urandom);
            w_in    = 16'($urandom);
            bias    = 31'($urandom);
            in_last = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: one comparison per handed-over result.
    always @(negedge clk) begin
        result_t e;
        if (reset && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_result", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("result%0d_x_out", resultCount), longint'($signed(x_out)), e.x);
                checkOutput($sformatf("result%0d_sat", resultCount), longint'(sat), e.s);
                resultCount++;
            end
        end
    end

    initial begin
        logic signed [30:0] tx;
        logic signed [15:0] tw;
        int      len;
        int      bv;
        int      guard;
        result_t e;

        // Reset state.
        readyMode  = 1'b0;
        readyForce = 1'b1;
        reset      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", longint'(in_ready), 0);
        checkOutput("rst_out_valid", longint'(out_valid), 0);
        checkOutput("rst_x_out", longint'(x_out), 0);
        checkOutput("rst_sat", longint'(sat), 0);
        reset = 1'b1;
        #1;
        checkOutput("in_ready_before_edge", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_edge", longint'(in_ready), 1);

        // Single beat with latency check.
        vx[0] = 100000000; vw[0] = 8192;
        applyStimulus(1, 1, 0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_T0", longint'(out_valid), 0);
        @(negedge clk);
        checkOutput("lat_T1", longint'(out_valid), 0);
        @(negedge clk);
        checkOutput("lat_T2", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        idleCycles(2);

        // Two-beat vector.
        vx[0] = 50000000;  vw[0] = 16384;
        vx[1] = -25000000; vw[1] = 8192;
        applyStimulus(2, 2, 10000000, 1'b1);
        idleCycles(3);

        // Positive saturation and floor rounding.
        vx[0] = 1000000000; vw[0] = 16384;
        applyStimulus(1, 1, 0, 1'b1);
        idleCycles(3);
        vx[0] = -1; vw[0] = 1;
        applyStimulus(1, 1, 0, 1'b1);
        idleCycles(3);
        vx[0] = -1000000000; vw[0] = 16384;
        applyStimulus(1, 1, 0, 1'b1);
        idleCycles(4);

        // Backpressure: hold the result five cycles with a beat waiting.
        readyForce = 1'b0;
        vx[0] = 300000000; vw[0] = -4096;
        vx[1] = 7;         vw[1] = 3;
        applyStimulus(2, 2, -5000, 1'b1);
        e = model(2, -5000);
        in_valid = 1'b1;
        x_in     = 31'd100000000;
        w_in     = 16'd8192;
        in_last  = 1'b1;
        bias     = 31'd0;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("bp_valid_timeout", 1, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d_out_valid", i), longint'(out_valid), 1);
            checkOutput($sformatf("bp%0d_x_out", i), longint'($signed(x_out)), e.x);
            checkOutput($sformatf("bp%0d_sat", i), longint'(sat), e.s);
            checkOutput($sformatf("bp%0d_in_ready", i), longint'(in_ready), 0);
            @(negedge clk);
        end
        readyForce = 1'b1;
        vx[0] = 100000000; vw[0] = 8192;
        applyStimulus(1, 1, 0, 1'b1);
        idleCycles(4);

        // Mid-vector reset: three beats of five, then reset.
        for (int i = 0; i < 5; i++) begin
            vx[i] = 200000000; vw[i] = 8192;
        end
        applyStimulus(3, 5, 1234, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        checkOutput("mrst_out_valid", longint'(out_valid), 0);
        checkOutput("mrst_x_out", longint'(x_out), 0);
        checkOutput("mrst_sat", longint'(sat), 0);
        checkOutput("mrst_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        vx[0] = 100000000; vw[0] = 8192;
        applyStimulus(1, 1, 0, 1'b1);
        idleCycles(4);

        // Back-to-back vectors with in_valid held high.
        vx[0] = 40000000; vw[0] = 8192;
        vx[1] = 10000000; vw[1] = 16384;
        applyStimulus(2, 2, 0, 1'b1);
        vx[0] = 30000000; vw[0] = -8192;
        applyStimulus(1, 1, 20000000, 1'b1);
        idleCycles(4);

        // Randomized vectors with a random consumer.
        readyMode = 1'b1;
        for (int v = 0; v < 30; v++) begin
            len = (v == 0) ? 256 : int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                if (v == 0 || $urandom_range(0, 1) == 1) begin
                    vx[i] = int'($urandom_range(0, 200000000)) - 100000000;
                end else begin
                    tx = 31'($urandom);
                    vx[i] = tx;
                end
                tw = 16'($urandom);
                vw[i] = tw;
            end
            tx = 31'($urandom);
            bv = ($urandom_range(0, 1) == 1) ? int'(tx) : int'($urandom_range(0, 100000)) - 50000;
            applyStimulus(len, len, bv, 1'b1);
            if ($urandom_range(0, 2) != 0) idleCycles(int'($urandom_range(0, 3)));
        end
        idleCycles(1);

        // Drain the scoreboard.
        readyMode  = 1'b0;
        readyForce = 1'b1;
        guard = 0;
        while (expQ.size() != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", longint'(expQ.size()), 0);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
